// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise data always wins ties.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W/8-1:0] i_rmask,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_resp,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W/8-1:0] d_rmask,
    input  logic [DATA_W/8-1:0] d_wmask,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_resp,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_rmask,
    output logic [DATA_W/8-1:0] mem_wmask,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    state_t state, state_nx;
    logic req_i, req_d, d_write, grant_i, grant_d, fetch_wins_tie;
    assign req_i   = |i_rmask;
    assign d_write = |d_wmask;
    assign req_d   = d_write || (|d_rmask);
`ifdef ARB_RR_EN
    logic last_d;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_d <= 1'b1;
        else if (grant_i || grant_d) last_d <= grant_d;
    assign fetch_wins_tie = last_d;
`else
    assign fetch_wins_tie = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        i_resp   = 1'b0;
        d_resp   = 1'b0;
        case (state)
            IDLE: begin
                grant_d  = req_d && (!req_i || !fetch_wins_tie);
                grant_i  = req_i && !grant_d;
                state_nx = grant_d ? BUSY_D : grant_i ? BUSY_I : IDLE;
            end
            BUSY_I: begin
                i_resp   = mem_resp;
                state_nx = mem_resp ? IDLE : BUSY_I;
            end
            BUSY_D: begin
                d_resp   = mem_resp;
                state_nx = mem_resp ? IDLE : BUSY_D;
            end
            default: state_nx = IDLE;
        endcase
        i_rdata = i_resp ? mem_rdata : '0;
        d_rdata = d_resp ? mem_rdata : '0;
    end
    // Masks are one-cycle pulses; address and write data hold until the next grant.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_rmask <= '0;
            mem_wmask <= '0;
            mem_wdata <= '0;
        end else begin
            mem_rmask <= '0;
            mem_wmask <= '0;
            if (grant_i) begin
                mem_addr  <= i_addr;
                mem_rmask <= i_rmask;
                mem_wdata <= '0;
            end else if (grant_d) begin
                mem_addr  <= d_addr;
                mem_rmask <= d_write ? '0 : d_rmask;
                mem_wmask <= d_wmask;
                mem_wdata <= d_write ? d_wdata : '0;
            end
        end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_mem_port_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  i_rmask, d_rmask, d_wmask, mem_rmask, mem_wmask;
    logic        i_resp, d_resp, mem_resp;
    int vectors = 0, miscompares = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_rmask(i_rmask), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_rmask(d_rmask), .d_wmask(d_wmask), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_addr = 0; i_rmask = 0; d_addr = 0; d_rmask = 0; d_wmask = 0; d_wdata = 0;
        mem_rdata = 0; mem_resp = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        i_rmask = 4'hF; i_addr = 32'h44; mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        vectors++;
        if ({mem_addr, mem_rmask, mem_wmask, mem_wdata} !== 72'h0) begin
            miscompares++;
            $display("FAIL reset_mem: got %h want 0", {mem_addr, mem_rmask, mem_wmask, mem_wdata});
        end
        vectors++;
        if ({i_resp, d_resp, i_rdata, d_rdata} !== 66'h0) begin
            miscompares++;
            $display("FAIL reset_resp: got %h want 0", {i_resp, d_resp, i_rdata, d_rdata});
        end
        tick();
        vectors++;
        if (mem_rmask !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_hold_rmask: got %h want 0", mem_rmask);
        end
        do_reset();
    endtask

    task automatic test_fetch_only();
        clear_inputs();
        i_addr = 32'h1000; i_rmask = 4'hF;
        tick();
        vectors++;
        if ({mem_addr, mem_rmask, mem_wmask, mem_wdata} !== {32'h1000, 4'hF, 4'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL fetch_cmd: got %h want %h", {mem_addr, mem_rmask, mem_wmask, mem_wdata}, {32'h1000, 4'hF, 4'h0, 32'h0});
        end
        tick();
        vectors++;
        if ({mem_addr, mem_rmask, i_resp} !== {32'h1000, 4'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL fetch_pulse: got %h want %h", {mem_addr, mem_rmask, i_resp}, {32'h1000, 4'h0, 1'b0});
        end
        tick();
        mem_resp = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        vectors++;
        if ({i_resp, i_rdata, d_resp, d_rdata} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL fetch_resp: got %h want %h", {i_resp, i_rdata, d_resp, d_rdata}, {1'b1, 32'hDEADBEEF, 1'b0, 32'h0});
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_store();
        clear_inputs();
        d_addr = 32'h2004; d_wmask = 4'h3; d_rmask = 4'hF; d_wdata = 32'h1234;
        tick();
        vectors++;
        if ({mem_addr, mem_rmask, mem_wmask, mem_wdata} !== {32'h2004, 4'h0, 4'h3, 32'h1234}) begin
            miscompares++;
            $display("FAIL store_cmd: got %h want %h", {mem_addr, mem_rmask, mem_wmask, mem_wdata}, {32'h2004, 4'h0, 4'h3, 32'h1234});
        end
        tick();
        vectors++;
        if ({mem_wmask, mem_wdata} !== {4'h0, 32'h1234}) begin
            miscompares++;
            $display("FAIL store_pulse: got %h want %h", {mem_wmask, mem_wdata}, {4'h0, 32'h1234});
        end
        mem_resp = 1'b1; mem_rdata = 32'h55;
        #1;
        vectors++;
        if ({d_resp, d_rdata, i_resp} !== {1'b1, 32'h55, 1'b0}) begin
            miscompares++;
            $display("FAIL store_resp: got %h want %h", {d_resp, d_rdata, i_resp}, {1'b1, 32'h55, 1'b0});
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_tie();
        logic first_d, second_d;
`ifdef ARB_RR_EN
        first_d = 1'b0; second_d = 1'b1;
`else
        first_d = 1'b1; second_d = 1'b1;
`endif
        do_reset();
        i_addr = 32'h100; i_rmask = 4'hF; d_addr = 32'h200; d_rmask = 4'hF;
        tick();
        vectors++;
        if ({mem_addr, mem_rmask} !== {(first_d ? 32'h200 : 32'h100), 4'hF}) begin
            miscompares++;
            $display("FAIL tie1_grant: got %h want %h", {mem_addr, mem_rmask}, {(first_d ? 32'h200 : 32'h100), 4'hF});
        end
        mem_resp = 1'b1; mem_rdata = 32'hA1;
        #1;
        vectors++;
        if ({i_resp, d_resp} !== {!first_d, first_d}) begin
            miscompares++;
            $display("FAIL tie1_resp: got %b want %b", {i_resp, d_resp}, {!first_d, first_d});
        end
        tick();
        mem_resp = 1'b0;
        #1;
        vectors++;
        if ({mem_rmask, i_resp, d_resp} !== 6'h0) begin
            miscompares++;
            $display("FAIL tie_gap: got %h want 0", {mem_rmask, i_resp, d_resp});
        end
        tick();
        vectors++;
        if ({mem_addr, mem_rmask} !== {(second_d ? 32'h200 : 32'h100), 4'hF}) begin
            miscompares++;
            $display("FAIL tie2_grant: got %h want %h", {mem_addr, mem_rmask}, {(second_d ? 32'h200 : 32'h100), 4'hF});
        end
        mem_resp = 1'b1;
        #1;
        vectors++;
        if ({i_resp, d_resp} !== {!second_d, second_d}) begin
            miscompares++;
            $display("FAIL tie2_resp: got %b want %b", {i_resp, d_resp}, {!second_d, second_d});
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_stray_resp();
        clear_inputs();
        mem_resp = 1'b1; mem_rdata = 32'h77;
        #1;
        vectors++;
        if ({i_resp, d_resp, i_rdata, d_rdata} !== 66'h0) begin
            miscompares++;
            $display("FAIL stray_resp: got %h want 0", {i_resp, d_resp, i_rdata, d_rdata});
        end
        tick();
        mem_resp = 1'b0;
        i_addr = 32'h88; i_rmask = 4'h1;
        #1;
        vectors++;
        if ({mem_rmask, mem_wmask} !== 8'h0) begin
            miscompares++;
            $display("FAIL stray_nocmd: got %h want 0", {mem_rmask, mem_wmask});
        end
        tick();
        vectors++;
        if ({mem_addr, mem_rmask} !== {32'h88, 4'h1}) begin
            miscompares++;
            $display("FAIL stray_then_fetch: got %h want %h", {mem_addr, mem_rmask}, {32'h88, 4'h1});
        end
        mem_resp = 1'b1;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        d_addr = 32'h300; d_rmask = 4'hF;
        tick();
        vectors++;
        if ({mem_addr, mem_rmask} !== {32'h300, 4'hF}) begin
            miscompares++;
            $display("FAIL mid_grant: got %h want %h", {mem_addr, mem_rmask}, {32'h300, 4'hF});
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({mem_addr, mem_rmask, mem_wmask, mem_wdata} !== 72'h0) begin
            miscompares++;
            $display("FAIL mid_reset_clear: got %h want 0", {mem_addr, mem_rmask, mem_wmask, mem_wdata});
        end
        clear_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        mem_resp = 1'b1; mem_rdata = 32'h99;
        #1;
        vectors++;
        if ({d_resp, i_resp, d_rdata} !== 34'h0) begin
            miscompares++;
            $display("FAIL mid_late_resp: got %h want 0", {d_resp, i_resp, d_rdata});
        end
        tick();
        mem_resp = 1'b0; i_addr = 32'h400; i_rmask = 4'hF;
        tick();
        vectors++;
        if ({mem_addr, mem_rmask} !== {32'h400, 4'hF}) begin
            miscompares++;
            $display("FAIL mid_fresh_fetch: got %h want %h", {mem_addr, mem_rmask}, {32'h400, 4'hF});
        end
        mem_resp = 1'b1; mem_rdata = 32'hCAFE;
        #1;
        vectors++;
        if ({i_resp, i_rdata} !== {1'b1, 32'hCAFE}) begin
            miscompares++;
            $display("FAIL mid_fresh_resp: got %h want %h", {i_resp, i_rdata}, {1'b1, 32'hCAFE});
        end
        tick();
        clear_inputs();
        tick();
    endtask

    // Reference: who owns the port, the command each grant should present, and requester behaviour.
    task automatic test_random(input int cycles);
        int owner = 0;
        bit last_d = 1'b1, fa = 0, da = 0, first_busy = 0, pick_d, ei, ed;
        logic [31:0] fad = 0, dad = 0, dwd = 0, e_addr = 0, e_wdata = 0;
        logic [3:0]  fm = 0, drm = 0, dwm = 0, e_rm = 0, e_wm = 0;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            if (!fa && $urandom_range(0, 2) == 0) begin
                fa = 1; fad = $urandom; fm = 4'($urandom_range(1, 15));
            end
            if (!da && $urandom_range(0, 2) == 0) begin
                da = 1; dad = $urandom; dwd = $urandom;
                if ($urandom_range(0, 1) == 1) begin
                    dwm = 4'($urandom_range(1, 15)); drm = 4'($urandom);
                end else begin
                    dwm = 0; drm = 4'($urandom_range(1, 15));
                end
            end
            i_addr = fad; i_rmask = fa ? fm : 4'h0;
            d_addr = dad; d_wdata = dwd;
            d_rmask = da ? drm : 4'h0; d_wmask = da ? dwm : 4'h0;
            mem_resp = (owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
            #1;
            ei = (owner == 1) && mem_resp;
            ed = (owner == 2) && mem_resp;
            vectors++;
            if ({i_resp, i_rdata, d_resp, d_rdata} !== {ei, (ei ? mem_rdata : 32'h0), ed, (ed ? mem_rdata : 32'h0)}) begin
                miscompares++;
                $display("FAIL rand_resp c=%0d: got %h want %h", c, {i_resp, i_rdata, d_resp, d_rdata},
                         {ei, (ei ? mem_rdata : 32'h0), ed, (ed ? mem_rdata : 32'h0)});
            end
            vectors++;
            if ({mem_addr, mem_rmask, mem_wmask, mem_wdata} !== {e_addr, e_rm, e_wm, e_wdata}) begin
                miscompares++;
                $display("FAIL rand_cmd c=%0d: got %h want %h", c, {mem_addr, mem_rmask, mem_wmask, mem_wdata},
                         {e_addr, e_rm, e_wm, e_wdata});
            end
            e_rm = 0; e_wm = 0;
            if (owner != 0) begin
                if (mem_resp) owner = 0;
            end else if (fa || da) begin
`ifdef ARB_RR_EN
                pick_d = da && (!fa || !last_d);
`else
                pick_d = da;
`endif
                last_d = pick_d;
                owner = pick_d ? 2 : 1;
                e_addr  = pick_d ? dad : fad;
                e_rm    = pick_d ? ((dwm != 0) ? 4'h0 : drm) : fm;
                e_wm    = pick_d ? dwm : 4'h0;
                e_wdata = (pick_d && dwm != 0) ? dwd : 32'h0;
            end
            first_busy = 0;
            if (ei) fa = 0;
            if (ed) da = 0;
            tick();
        end
        clear_inputs();
        tick();
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_fetch_only();
        test_store();
        test_tie();
        test_stray_resp();
        test_reset_mid();
        test_random(600);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single unified memory port between the pipeline's instruction fetch stage and its data memory stage (loads/stores flagged by `memread_d`/`memwrite_d` in decode). It accepts mask-qualified requests from both sides and issues one registered memory command at a time. It tracks the single outstanding transaction with a small FSM and steers `mem_resp`/`mem_rdata` back to the granted requester.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; mask width is `DATA_W/8`
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `i_addr`  in  ADDR_W  fetch address
- `i_rmask`  in  DATA_W/8  fetch read mask; nonzero = fetch request
- `i_rdata`  out  DATA_W  fetch read data
- `i_resp`  out  1  fetch completion pulse
- `d_addr`  in  ADDR_W  data address
- `d_rmask`  in  DATA_W/8  load mask
- `d_wmask`  in  DATA_W/8  store mask
- `d_wdata`  in  DATA_W  store data
- `d_rdata`  out  DATA_W  load data
- `d_resp`  out  1  data completion pulse
- `mem_addr`  out  ADDR_W  memory address (registered)
- `mem_rmask`  out  DATA_W/8  memory read mask (registered, one-cycle pulse)
- `mem_wmask`  out  DATA_W/8  memory write mask (registered, one-cycle pulse)
- `mem_wdata`  out  DATA_W  memory write data (registered)
- `mem_rdata`  in  DATA_W  memory read data
- `mem_resp`  in  1  memory completion

## Operation
- Data request exists when `d_rmask != 0` or `d_wmask != 0`. If `d_wmask != 0`, it is a write and `d_rmask` is ignored.
- Fetch request exists when `i_rmask != 0`.
- Requesters hold address, masks and data stable from assertion until their `*_resp` cycle.
- FSM states:
  - IDLE: no outstanding transaction.
  - BUSY_I: fetch outstanding.
  - BUSY_D: data outstanding.
- IDLE transitions:
  - No request: stay in IDLE.
  - Single request: grant it and go to BUSY_I or BUSY_D.
  - Simultaneous requests: resolved per Configuration.
- On grant edge:
  - `mem_addr` and `mem_wdata` are loaded from the winner; `mem_wdata` is zero for reads and fetches.
  - The winner's masks are loaded into `mem_rmask`/`mem_wmask`.
- `mem_rmask`/`mem_wmask` are nonzero only in the first BUSY cycle and cleared on the following edge. `mem_addr`/`mem_wdata` hold until the response.
- In BUSY_x, when `mem_resp`=1:
  - `x_resp`=1 in that same cycle (combinational).
  - `x_rdata`=`mem_rdata`.
  - FSM returns to IDLE on that edge.
- `*_rdata` is zero when the matching `*_resp` is 0.
- Requests are not sampled during the response cycle. A requester still presenting a nonzero mask in the following IDLE cycle is treated as a new request.
- `mem_resp` seen in IDLE is ignored: no `*_resp` and no state change.
- A request from the non-granted side stays pending and is evaluated in the next IDLE cycle.

## Timing
- Reset (async assert, synchronous-safe deassert on `clk`):
  - State goes to IDLE.
  - `mem_addr`, `mem_rmask`, `mem_wmask`, `mem_wdata` = 0.
  - `i_resp`, `d_resp` = 0; `i_rdata`, `d_rdata` = 0.
  - Last-grant register = data.
- Reset mid-transaction: the outstanding transaction is abandoned. A later `mem_resp` lands in IDLE and is dropped.
- Request seen in IDLE at cycle T: the command is visible on `mem_*` at T+1.
- Earliest `mem_resp` is T+1 (zero-wait memory). That gives a `*_resp` at T+1 and the next grant decision at T+2.
- Minimum spacing between issued commands is 2 cycles. Total latency is 1 + memory wait cycles.

## Configuration
- `ARB_RR_EN` defined: round-robin on simultaneous requests. The side not granted last wins. Last-grant updates on every grant and resets to data, so fetch wins the first tie.
- `ARB_RR_EN` undefined: fixed priority, data always wins ties. The last-grant register is not implemented.

## Test plan
- Fetch only: `i_addr`=0x1000, `i_rmask`=0xF at T, mem responds at T+3 with 0xDEADBEEF -> at T+1 `mem_rmask`=0xF, `mem_addr`=0x1000; at T+2 `mem_rmask`=0; at T+3 `i_resp`=1, `i_rdata`=0xDEADBEEF, `d_resp`=0.
- Store: `d_addr`=0x2004, `d_wmask`=0x3, `d_rmask`=0xF, `d_wdata`=0x1234 -> `mem_wmask`=0x3, `mem_rmask`=0, `mem_wdata`=0x1234 for one cycle; `mem_resp` -> `d_resp`=1.
- Simultaneous fetch+load, zero-wait memory:
  - Without `ARB_RR_EN`: data is granted first, fetch command issues 2 cycles later.
  - With it: fetch first, then data; a second tie grants the opposite side.
- Stray `mem_resp`=1 while IDLE -> `i_resp`=`d_resp`=0, no command issued.
- `rst_n` low while in BUSY_D -> all `mem_*` outputs 0 immediately; a `mem_resp` after release produces no `d_resp`; a fresh fetch is then served normally.
